phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
Multi-cycle core phase controller. Drives the one-hot phase strobes (fetch, decode, execute, memory, writeback) that sequence top_fetch and the downstream stages. Honours stage stall requests, supports debug halt/resume, flags stalls that exceed a limit, and keeps cycle and retired-instruction counters.

Parameters:
CNT_WIDTH, 32, width of cycle_count and instret_count.
STALL_LIMIT, 256, consecutive stall cycles in one phase that trigger stall_timeout; must be at least 2.
SW, 9, width of the internal stall counter; must satisfy 2^SW > STALL_LIMIT.

Ports:
clk  in  1  global clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
stall_fetch  in  1  fetch stage not ready; holds FETCH.
stall_memory  in  1  data memory access not complete; holds MEMORY.
halt_req  in  1  request to halt after the current instruction retires.
resume  in  1  leave HALT.
phase_fetch  out  1  FETCH phase strobe.
phase_decode  out  1  DECODE phase strobe.
phase_execute  out  1  EXECUTE phase strobe.
phase_memory  out  1  MEMORY phase strobe.
phase_writeback  out  1  WRITEBACK phase strobe.
halted  out  1  high while in HALT.
stall_timeout  out  1  sticky; a stall reached STALL_LIMIT.
cycle_count  out  CNT_WIDTH  clocks since reset.
instret_count  out  CNT_WIDTH  retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. All outputs are decoded from registered state only, with no combinational path from inputs. At most one phase strobe is high at any time, and none is high in IDLE or HALT.
- Reset (async, any time, including mid-instruction):
  - state = IDLE; all phase strobes 0.
  - halted 0, stall_timeout 0, both counters 0.
  - pending_halt 0, stall counter 0.
- Transitions, per rising edge:
  - IDLE -> FETCH unconditionally on the first edge after rst falls.
  - FETCH -> DECODE if !stall_fetch, else hold FETCH.
  - DECODE -> EXECUTE -> MEMORY, one cycle each.
  - MEMORY -> WRITEBACK if !stall_memory, else hold MEMORY.
  - WRITEBACK -> HALT if (pending_halt | halt_req), else -> FETCH.
  - HALT -> FETCH if resume, else hold HALT.
  - Stall inputs are ignored outside their own phase.
  - An unstalled instruction takes exactly 5 cycles (FETCH to FETCH).
- pending_halt:
  - Set when halt_req = 1 in any state other than HALT.
  - Cleared on entering HALT.
  - halt_req never aborts an instruction in flight.
  - halt_req = 1 in IDLE causes a halt after the first instruction retires.
- HALT:
  - halted = 1.
  - resume and halt_req both high in HALT: resume wins and pending_halt stays 0.
  - Leaving HALT clears stall_timeout.
- Stall watchdog:
  - The stall counter increments each cycle the state holds because of a stall.
  - It clears whenever the state advances.
  - When it reaches STALL_LIMIT, set stall_timeout (sticky) and force next state = HALT, overriding the stall. The stall counter then clears.
  - stall_timeout clears only on reset or on leaving HALT.
- Counters:
  - cycle_count increments every edge except when rst is asserted, including IDLE and HALT.
  - instret_count increments on each edge where state = WRITEBACK.
  - Both wrap modulo 2^CNT_WIDTH with no saturation or flag.

Test Plan:
- Reset, release rst, no stalls, 20 cycles -> phase_fetch high on edge 1 after release; phases cycle F,D,E,M,W with period 5; instret_count = 4 at edge 21; cycle_count = 20 after 20 edges.
- stall_fetch high for 3 cycles during the first FETCH -> FETCH held 4 cycles; phase_decode first high on edge 5; no other phase disturbed.
- stall_memory high 10 cycles with STALL_LIMIT = 4 -> stall_timeout = 1 and halted = 1 after 4 held cycles; instret_count unchanged; resume pulse -> FETCH next edge, stall_timeout = 0.
- halt_req 1-cycle pulse during EXECUTE -> WRITEBACK completes and instret_count increments; state = HALT, halted = 1; resume held high 1 cycle together with halt_req -> FETCH, no re-halt.
- rst asserted mid-MEMORY without a clock edge -> all phase strobes 0 and counters 0 immediately; after release, FETCH on the first edge.
- Preload counters via force to 0xFFFF_FFFF, then run one instruction -> instret_count wraps to 0; cycle_count wraps to 0 with no side effects.

Source files
------------

// File: rtl/phase_sequencer.sv
// Multi-cycle core phase controller: one-hot phase strobes, stall handling with
// a watchdog, debug halt/resume, and cycle / retired-instruction counters.
module phase_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int STALL_LIMIT = 256,
  parameter int SW          = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_fetch,
  input  logic                 stall_memory,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 phase_fetch,
  output logic                 phase_decode,
  output logic                 phase_execute,
  output logic                 phase_memory,
  output logic                 phase_writeback,
  output logic                 halted,
  output logic                 stall_timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic          pending_halt, pending_nxt;
  logic [SW-1:0] stall_cnt, stall_cnt_nxt;
  logic          stalled, stall_hit;

  // The watchdog fires once the counter has recorded STALL_LIMIT held cycles,
  // and its forced HALT takes priority over whatever the phase logic chose.
  always_comb begin
    state_nxt = state;
    stalled   = 1'b0;
    stall_hit = (stall_cnt == SW'(STALL_LIMIT));
    case (state)
      S_IDLE:      state_nxt = S_FETCH;
      S_FETCH:     if (stall_fetch) stalled = 1'b1; else state_nxt = S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_MEMORY;
      S_MEMORY:    if (stall_memory) stalled = 1'b1; else state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = (pending_halt || halt_req) ? S_HALT : S_FETCH;
      S_HALT:      if (resume) state_nxt = S_FETCH;
      default:     state_nxt = S_IDLE;
    endcase
    if (stall_hit) state_nxt = S_HALT;

    stall_cnt_nxt = (stalled && !stall_hit) ? stall_cnt + 1'b1 : '0;

    pending_nxt = pending_halt;
    if (state != S_HALT && halt_req) pending_nxt = 1'b1;
    if (state_nxt == S_HALT) pending_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      pending_halt    <= 1'b0;
      stall_cnt       <= '0;
      phase_fetch     <= 1'b0;
      phase_decode    <= 1'b0;
      phase_execute   <= 1'b0;
      phase_memory    <= 1'b0;
      phase_writeback <= 1'b0;
      halted          <= 1'b0;
      stall_timeout   <= 1'b0;
      cycle_count     <= '0;
      instret_count   <= '0;
    end else begin
      state           <= state_nxt;
      pending_halt    <= pending_nxt;
      stall_cnt       <= stall_cnt_nxt;
      phase_fetch     <= (state_nxt == S_FETCH);
      phase_decode    <= (state_nxt == S_DECODE);
      phase_execute   <= (state_nxt == S_EXECUTE);
      phase_memory    <= (state_nxt == S_MEMORY);
      phase_writeback <= (state_nxt == S_WRITEBACK);
      halted          <= (state_nxt == S_HALT);
      if (stall_hit)
        stall_timeout <= 1'b1;
      else if (state == S_HALT && state_nxt != S_HALT)
        stall_timeout <= 1'b0;
      cycle_count     <= cycle_count + 1'b1;
      if (state == S_WRITEBACK)
        instret_count <= instret_count + 1'b1;
    end
  end

endmodule
